// File: rtl/bcrypt_proxy_arbiter_pkg.sv
// Shared types for the bcrypt proxy arbiter: packet control codes, FSM state
// encodings and small index helpers.
package bcrypt_proxy_arbiter_pkg;

    typedef enum logic [1:0] {
        CTRL_NONE       = 2'b00,
        CTRL_DATA_START = 2'b01,
        CTRL_INIT_START = 2'b10,
        CTRL_END        = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_FWD,
        IN_HOLD
    } in_state_e;

    typedef enum logic [2:0] {
        OUT_SCAN,
        OUT_REQ,
        OUT_WAIT,
        OUT_SHIFT,
        OUT_EMIT
    } out_state_e;

    function automatic int wrap_inc(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcrypt_proxy_arbiter_rr_pick.sv
// Round-robin first-set search: returns the first set bit of vec at or after
// start, wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [N-1:0] rot;
    int           j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        rot   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            rot = vec >> j;
            if (!found && rot[0]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/bcrypt_proxy_arbiter.sv
// Routes the bcrypt_data packet stream to NUM_PROXIES proxies and collects
// their serial results back into an upstream byte stream.
module bcrypt_proxy_arbiter
    import bcrypt_proxy_arbiter_pkg::*;
#(
    parameter int NUM_PROXIES = 2,
    parameter int PKT_BITS    = 16,
    parameter int RD_LATENCY  = 2,
    parameter int HOLDOFF     = 4,
    localparam int IDX_W      = width_of(NUM_PROXIES)
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [7:0]             din,
    input  logic [1:0]             ctrl,
    input  logic                   wr_en,
    output logic                   init_ready,
    output logic                   crypt_ready,
    output logic                   err,
    output logic [7:0]             px_din,
    output logic [1:0]             px_ctrl,
    output logic [NUM_PROXIES-1:0] px_wr_en,
    input  logic [NUM_PROXIES-1:0] px_init_ready,
    input  logic [NUM_PROXIES-1:0] px_crypt_ready,
    output logic [NUM_PROXIES-1:0] px_rd_en,
    input  logic [NUM_PROXIES-1:0] px_empty,
    input  logic [NUM_PROXIES-1:0] px_dout,
    output logic [7:0]             dout,
    output logic [IDX_W-1:0]       dout_proxy,
    output logic                   dout_valid,
    input  logic                   dout_rd
);

    localparam int PKT_BYTES = PKT_BITS / 8;
    localparam int HOLD_W    = width_of(HOLDOFF);
    localparam int LAT_W     = width_of(RD_LATENCY);
    localparam int BIT_W     = width_of(PKT_BITS);
    localparam int BYTE_W    = width_of(PKT_BYTES);

    // ---------------- input side ----------------
    in_state_e              in_state_q, in_state_d;
    logic [NUM_PROXIES-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]       rr_in_q, rr_in_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   err_q, err_d;
    logic                   init_ready_q, init_ready_d;
    logic                   crypt_ready_q, crypt_ready_d;
    logic [7:0]             px_din_q;
    logic [1:0]             px_ctrl_q;
    logic [NUM_PROXIES-1:0] px_wr_en_q, px_wr_en_d;
    logic [IDX_W-1:0]       in_sel;
    logic                   in_found;

    rr_pick #(.N(NUM_PROXIES), .W(IDX_W)) u_pick_in (
        .vec   (px_crypt_ready),
        .start (rr_in_q),
        .idx   (in_sel),
        .found (in_found)
    );

    always_comb begin
        in_state_d = in_state_q;
        mask_d     = mask_q;
        rr_in_d    = rr_in_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = err_q;
        px_wr_en_d = '0;
        case (in_state_q)
            IN_IDLE: begin
                if (wr_en && ctrl == CTRL_DATA_START) begin
                    if (in_found) begin
                        mask_d  = NUM_PROXIES'(1) << in_sel;
                        rr_in_d = IDX_W'(wrap_inc(int'(in_sel), NUM_PROXIES));
                    end else begin
                        mask_d = '0;
                        err_d  = 1'b1;
                    end
                    px_wr_en_d = mask_d;
                    in_state_d = IN_FWD;
                end else if (wr_en && ctrl == CTRL_INIT_START) begin
                    mask_d = px_init_ready;
                    if (px_init_ready == '0) begin
                        err_d = 1'b1;
                    end
                    px_wr_en_d = mask_d;
                    in_state_d = IN_FWD;
                end
            end
            IN_FWD: begin
                if (wr_en) begin
                    px_wr_en_d = mask_q;
                    if (ctrl == CTRL_END) begin
                        mask_d     = '0;
                        hold_cnt_d = '0;
                        in_state_d = (HOLDOFF == 0) ? IN_IDLE : IN_HOLD;
                    end
                end
            end
            IN_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLDOFF - 1)) begin
                    in_state_d = IN_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
        // Ready only once IDLE is settled, so it drops the cycle a start is taken.
        crypt_ready_d = (in_state_q == IN_IDLE) && (in_state_d == IN_IDLE) && (|px_crypt_ready);
        init_ready_d  = (in_state_q == IN_IDLE) && (in_state_d == IN_IDLE) && (|px_init_ready);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            in_state_q    <= IN_IDLE;
            mask_q        <= '0;
            rr_in_q       <= '0;
            hold_cnt_q    <= '0;
            err_q         <= 1'b0;
            init_ready_q  <= 1'b0;
            crypt_ready_q <= 1'b0;
            px_din_q      <= '0;
            px_ctrl_q     <= '0;
            px_wr_en_q    <= '0;
        end else begin
            in_state_q    <= in_state_d;
            mask_q        <= mask_d;
            rr_in_q       <= rr_in_d;
            hold_cnt_q    <= hold_cnt_d;
            err_q         <= err_d;
            init_ready_q  <= init_ready_d;
            crypt_ready_q <= crypt_ready_d;
            px_din_q      <= din;
            px_ctrl_q     <= ctrl;
            px_wr_en_q    <= px_wr_en_d;
        end
    end

    // ---------------- output side ----------------
    out_state_e             out_state_q, out_state_d;
    logic [IDX_W-1:0]       rr_out_q, rr_out_d;
    logic [IDX_W-1:0]       dout_proxy_q, dout_proxy_d;
    logic [NUM_PROXIES-1:0] px_rd_en_q, px_rd_en_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [PKT_BITS-1:0]    sr_q, sr_d;
    logic [7:0]             dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic [NUM_PROXIES-1:0] avail;
    logic [NUM_PROXIES-1:0] dout_rot;
    logic [IDX_W-1:0]       out_sel;
    logic                   out_found;

    assign avail    = ~px_empty;
    assign dout_rot = px_dout >> rr_out_q;

    rr_pick #(.N(NUM_PROXIES), .W(IDX_W)) u_pick_out (
        .vec   (avail),
        .start (rr_out_q),
        .idx   (out_sel),
        .found (out_found)
    );

    always_comb begin
        out_state_d  = out_state_q;
        rr_out_d     = rr_out_q;
        dout_proxy_d = dout_proxy_q;
        lat_cnt_d    = lat_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        sr_d         = sr_q;
        px_rd_en_d   = '0;
        case (out_state_q)
            OUT_SCAN: begin
                if (out_found) begin
                    rr_out_d     = out_sel;
                    dout_proxy_d = out_sel;
                    px_rd_en_d   = NUM_PROXIES'(1) << out_sel;
                    out_state_d  = OUT_REQ;
                end
            end
            OUT_REQ: begin
                lat_cnt_d   = '0;
                bit_cnt_d   = '0;
                out_state_d = (RD_LATENCY <= 1) ? OUT_SHIFT : OUT_WAIT;
            end
            OUT_WAIT: begin
                if (lat_cnt_q == LAT_W'(RD_LATENCY - 2)) begin
                    out_state_d = OUT_SHIFT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            OUT_SHIFT: begin
                sr_d = {sr_q[PKT_BITS-2:0], dout_rot[0]};
                if (bit_cnt_q == BIT_W'(PKT_BITS - 1)) begin
                    byte_cnt_d  = '0;
                    out_state_d = OUT_EMIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            OUT_EMIT: begin
                if (dout_valid_q && dout_rd) begin
                    sr_d = sr_q << 8;
                    if (byte_cnt_q == BYTE_W'(PKT_BYTES - 1)) begin
                        rr_out_d    = IDX_W'(wrap_inc(int'(rr_out_q), NUM_PROXIES));
                        out_state_d = OUT_SCAN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: out_state_d = OUT_SCAN;
        endcase
        // The presented byte is always the top of the shift register.
        dout_valid_d = (out_state_d == OUT_EMIT);
        dout_d       = dout_valid_d ? sr_d[PKT_BITS-1 -: 8] : 8'h00;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_state_q  <= OUT_SCAN;
            rr_out_q     <= '0;
            dout_proxy_q <= '0;
            px_rd_en_q   <= '0;
            lat_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            sr_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            out_state_q  <= out_state_d;
            rr_out_q     <= rr_out_d;
            dout_proxy_q <= dout_proxy_d;
            px_rd_en_q   <= px_rd_en_d;
            lat_cnt_q    <= lat_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign init_ready  = init_ready_q;
    assign crypt_ready = crypt_ready_q;
    assign err         = err_q;
    assign px_din      = px_din_q;
    assign px_ctrl     = px_ctrl_q;
    assign px_wr_en    = px_wr_en_q;
    assign px_rd_en    = px_rd_en_q;
    assign dout        = dout_q;
    assign dout_proxy  = dout_proxy_q;
    assign dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_bcrypt_proxy_arbiter.sv
// Directed bench for bcrypt_proxy_arbiter: vector table for input routing plus
// hand-written sequences for reset, init broadcast, readback and wrap-around.
module tb_bcrypt_proxy_arbiter;
    import bcrypt_proxy_arbiter_pkg::*;

    localparam int RD_LAT = 2;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] ctrl = 2'b00;
    logic       wr_en = 1'b0;
    logic       init_ready, crypt_ready, err;
    logic [7:0] px_din;
    logic [1:0] px_ctrl;
    logic [1:0] px_wr_en;
    logic [1:0] px_init_ready = 2'b00;
    logic [1:0] px_crypt_ready = 2'b00;
    logic [1:0] px_rd_en;
    logic [1:0] px_empty;
    logic [1:0] px_dout = 2'b00;
    logic [7:0] dout;
    logic [0:0] dout_proxy;
    logic       dout_valid;
    logic       dout_rd = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Proxy model state: pend_add written by the test, pend_done by the model.
    int          pend_add [2] = '{0, 0};
    int          pend_done[2] = '{0, 0};
    logic [15:0] base[2] = '{16'h1E2D, 16'hA5C3};
    int          rd_log[$];
    int          rd_cycles = 0;
    logic        model_busy = 1'b0;
    logic        collect = 1'b0;
    logic [7:0]  col_byte[$];
    int          col_px[$];

    assign px_empty = {pend_add[1] == pend_done[1], pend_add[0] == pend_done[0]};

    bcrypt_proxy_arbiter #(
        .NUM_PROXIES (2),
        .PKT_BITS    (16),
        .RD_LATENCY  (RD_LAT),
        .HOLDOFF     (4)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .din            (din),
        .ctrl           (ctrl),
        .wr_en          (wr_en),
        .init_ready     (init_ready),
        .crypt_ready    (crypt_ready),
        .err            (err),
        .px_din         (px_din),
        .px_ctrl        (px_ctrl),
        .px_wr_en       (px_wr_en),
        .px_init_ready  (px_init_ready),
        .px_crypt_ready (px_crypt_ready),
        .px_rd_en       (px_rd_en),
        .px_empty       (px_empty),
        .px_dout        (px_dout),
        .dout           (dout),
        .dout_proxy     (dout_proxy),
        .dout_valid     (dout_valid),
        .dout_rd        (dout_rd)
    );

    always #5 CLK = ~CLK;

    // Proxy model: after seeing rd_en, wait RD_LAT edges then stream 16 bits MSB first.
    always begin
        @(posedge CLK);
        #1;
        if (px_rd_en != 2'b00) begin
            int          idx;
            logic [15:0] pkt;
            idx = px_rd_en[1] ? 1 : 0;
            rd_log.push_back(idx);
            pkt = base[idx] + 16'(pend_done[idx]) * 16'h0101;
            pend_done[idx] = pend_done[idx] + 1;
            model_busy = 1'b1;
            repeat (RD_LAT) @(posedge CLK);
            #1;
            for (int b = 15; b >= 0; b--) begin
                px_dout[idx] = pkt[b];
                @(posedge CLK);
                #1;
            end
            px_dout = 2'b00;
            model_busy = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (px_rd_en != 2'b00) rd_cycles++;
        if (collect && dout_valid && dout_rd) begin
            col_byte.push_back(dout);
            col_px.push_back(int'(dout_proxy));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [1:0] c, input logic [7:0] d);
        wr_en = w;
        ctrl  = c;
        din   = d;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] c;
        logic [7:0] d;
        logic [1:0] exp_wr;
        logic       exp_cr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic w, input logic [1:0] c, input logic [7:0] d,
                       input logic [1:0] ew, input logic ecr);
        vec_t v;
        v.wr = w; v.c = c; v.d = d; v.exp_wr = ew; v.exp_cr = ecr;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int exp_px[6];
        logic [7:0] exp_b[6];

        // Round-robin DATA dispatch with HOLD gaps; a start inside HOLD is ignored.
        add(0, CTRL_NONE,       8'h00, 2'b00, 1);
        add(1, CTRL_DATA_START, 8'h11, 2'b01, 0);
        add(1, CTRL_NONE,       8'h22, 2'b01, 0);
        add(1, CTRL_END,        8'h33, 2'b01, 0);
        add(0, CTRL_NONE,       8'h44, 2'b00, 0);
        add(1, CTRL_DATA_START, 8'h55, 2'b00, 0);
        add(0, CTRL_NONE,       8'h66, 2'b00, 0);
        add(0, CTRL_NONE,       8'h77, 2'b00, 0);
        add(0, CTRL_NONE,       8'h88, 2'b00, 1);
        add(1, CTRL_DATA_START, 8'h99, 2'b10, 0);
        add(1, CTRL_END,        8'hAA, 2'b10, 0);
        add(0, CTRL_NONE,       8'h01, 2'b00, 0);
        add(0, CTRL_NONE,       8'h02, 2'b00, 0);
        add(0, CTRL_NONE,       8'h03, 2'b00, 0);
        add(0, CTRL_NONE,       8'h04, 2'b00, 0);
        add(0, CTRL_NONE,       8'h05, 2'b00, 1);
        add(1, CTRL_DATA_START, 8'hBB, 2'b01, 0);
        add(1, CTRL_END,        8'hCC, 2'b01, 0);
        add(0, CTRL_NONE,       8'hDD, 2'b00, 0);

        // Reset state
        @(posedge CLK);
        #1;
        check("rst_px_wr_en", 32'(px_wr_en), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_crypt_ready", 32'(crypt_ready), 32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_px_rd_en", 32'(px_rd_en), 32'h0);
        RESET_N = 1'b1;
        px_crypt_ready = 2'b11;

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].c, tbl[i].d);
            check($sformatf("rr_wr_en[%0d]", i), 32'(px_wr_en), 32'(tbl[i].exp_wr));
            check($sformatf("rr_crypt_ready[%0d]", i), 32'(crypt_ready), 32'(tbl[i].exp_cr));
            check($sformatf("rr_px_ctrl[%0d]", i), 32'(px_ctrl), 32'(tbl[i].c));
            check($sformatf("rr_px_din[%0d]", i), 32'(px_din), 32'(tbl[i].d));
            check($sformatf("rr_err[%0d]", i), 32'(err), 32'h0);
        end

        // Init broadcast to both proxies
        px_init_ready = 2'b11;
        repeat (5) step(0, CTRL_NONE, 8'h00);
        check("init_ready_idle", 32'(init_ready), 32'h1);
        step(1, CTRL_INIT_START, 8'h10);
        check("init_wr_en[0]", 32'(px_wr_en), 32'h3);
        for (int k = 1; k <= 3; k++) begin
            step(1, CTRL_NONE, 8'(8'h10 + k));
            check($sformatf("init_wr_en[%0d]", k), 32'(px_wr_en), 32'h3);
        end
        step(1, CTRL_END, 8'h14);
        check("init_wr_en[4]", 32'(px_wr_en), 32'h3);
        check("init_end_ctrl", 32'(px_ctrl), 32'(CTRL_END));
        step(0, CTRL_NONE, 8'h00);
        check("init_wr_en_after", 32'(px_wr_en), 32'h0);
        check("init_ready_hold", 32'(init_ready), 32'h0);

        // No ready proxy: packet dropped, err sticky
        px_init_ready = 2'b00;
        px_crypt_ready = 2'b00;
        repeat (6) step(0, CTRL_NONE, 8'h00);
        check("noready_crypt_ready", 32'(crypt_ready), 32'h0);
        step(1, CTRL_DATA_START, 8'h21);
        check("noready_wr_en0", 32'(px_wr_en), 32'h0);
        check("noready_err", 32'(err), 32'h1);
        step(1, CTRL_NONE, 8'h22);
        check("noready_wr_en1", 32'(px_wr_en), 32'h0);
        step(1, CTRL_END, 8'h23);
        check("noready_wr_en2", 32'(px_wr_en), 32'h0);
        repeat (6) step(0, CTRL_NONE, 8'h00);
        check("noready_err_sticky", 32'(err), 32'h1);

        // Reset while input is in FWD and output is in SHIFT
        px_crypt_ready = 2'b11;
        step(0, CTRL_NONE, 8'h00);
        n0 = rd_log.size();
        pend_add[0] = pend_add[0] + 1;
        step(1, CTRL_DATA_START, 8'h31);
        check("fwd_wr_en", 32'(px_wr_en), 32'h2);
        for (int i = 0; i < 20 && rd_log.size() == n0; i++) step(1, CTRL_NONE, 8'h5A);
        check("rst_rd_seen", 32'(rd_log.size()), 32'(n0 + 1));
        repeat (4) step(1, CTRL_NONE, 8'h5B);
        check("fwd_wr_en_mid", 32'(px_wr_en), 32'h2);
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_rst_px_wr_en", 32'(px_wr_en), 32'h0);
        check("mid_rst_px_din", 32'(px_din), 32'h0);
        check("mid_rst_px_ctrl", 32'(px_ctrl), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_crypt_ready", 32'(crypt_ready), 32'h0);
        check("mid_rst_px_rd_en", 32'(px_rd_en), 32'h0);
        check("mid_rst_dout_valid", 32'(dout_valid), 32'h0);
        check("mid_rst_dout", 32'(dout), 32'h0);
        wr_en = 1'b0;
        ctrl = CTRL_NONE;
        RESET_N = 1'b1;
        for (int i = 0; i < 40 && model_busy; i++) step(0, CTRL_NONE, 8'h00);
        repeat (5) step(0, CTRL_NONE, 8'h00);
        check("post_rst_dout_valid", 32'(dout_valid), 32'h0);
        check("post_rst_err", 32'(err), 32'h0);

        // Readback from proxy 1 with upstream back-pressure
        n0 = rd_log.size();
        pend_add[1] = pend_add[1] + 1;
        for (int i = 0; i < 60 && dout_valid !== 1'b1; i++) begin
            @(posedge CLK);
            #1;
        end
        check("rb_valid", 32'(dout_valid), 32'h1);
        check("rb_byte0", 32'(dout), 32'hA5);
        check("rb_proxy", 32'(dout_proxy), 32'h1);
        check("rb_rd_pulses", 32'(rd_log.size()), 32'(n0 + 1));
        check("rb_rd_idx", 32'(rd_log[rd_log.size() - 1]), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            check($sformatf("rb_hold_byte[%0d]", i), 32'(dout), 32'hA5);
        end
        check("rb_hold_valid", 32'(dout_valid), 32'h1);
        dout_rd = 1'b1;
        @(posedge CLK);
        #1;
        check("rb_byte1", 32'(dout), 32'hC3);
        check("rb_byte1_proxy", 32'(dout_proxy), 32'h1);
        @(posedge CLK);
        #1;
        dout_rd = 1'b0;
        check("rb_done_valid", 32'(dout_valid), 32'h0);
        check("rb_single_read", 32'(rd_log.size()), 32'(n0 + 1));

        // Wrap and concurrency: reads 0,1,0 while a DATA packet goes to proxy 0
        exp_px = '{0, 0, 1, 1, 0, 0};
        exp_b  = '{8'h1F, 8'h2E, 8'hA6, 8'hC4, 8'h20, 8'h2F};
        n0 = rd_log.size();
        collect = 1'b1;
        dout_rd = 1'b1;
        pend_add[0] = pend_add[0] + 2;
        pend_add[1] = pend_add[1] + 1;
        step(1, CTRL_DATA_START, 8'h41);
        check("cc_wr_en0", 32'(px_wr_en), 32'h1);
        step(1, CTRL_NONE, 8'h42);
        check("cc_wr_en1", 32'(px_wr_en), 32'h1);
        step(1, CTRL_END, 8'h43);
        check("cc_wr_en2", 32'(px_wr_en), 32'h1);
        for (int i = 0; i < 300 && col_byte.size() < 6; i++) step(0, CTRL_NONE, 8'h00);
        check("cc_bytes", 32'(col_byte.size()), 32'd6);
        for (int i = 0; i < 6 && i < col_byte.size(); i++) begin
            check($sformatf("cc_byte[%0d]", i), 32'(col_byte[i]), 32'(exp_b[i]));
            check($sformatf("cc_proxy[%0d]", i), 32'(col_px[i]), 32'(exp_px[i]));
        end
        check("cc_reads", 32'(rd_log.size()), 32'(n0 + 3));
        for (int i = 0; i < 3 && n0 + i < rd_log.size(); i++) begin
            check($sformatf("cc_rd_order[%0d]", i), 32'(rd_log[n0 + i]), 32'(exp_px[2 * i]));
        end
        check("rd_pulse_width", 32'(rd_cycles), 32'(rd_log.size()));
        collect = 1'b0;
        dout_rd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
